steer_frame_engine: RTL and testbench

Single-clock, parametrised successor to the byte-load/steer datapath. Bytes arrive on a valid/ready stream and are buffered in an internal memory. They are then drained as frames of LANES bytes steered onto a flattened multi-lane output bus, with a per-lane mask for short frames. The block replaces the fixed 8-output steer path and its start/complete control with one engine that has a length register, backpressure, abort, error reporting and a live monitor tap.

---
 rtl/steer_frame_engine.sv | 162 ++++++++++++++++
 tb/tb_steer_frame_engine.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/steer_frame_engine.sv
`default_nettype none
// ============================================================================
// Module   : steer_frame_engine
// Purpose  : Buffers a byte stream, then drains it as LANES-wide masked frames.
// Revision : 1.0 - initial release
// ============================================================================
module steer_frame_engine #(
  parameter int DATA_W = 8,
  parameter int LANES  = 8,
  parameter int DEPTH  = 64,
  parameter int LEN_W  = $clog2(DEPTH) + 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    abort,
  input  logic                    tap_en,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        out_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       tap_data,
  output logic                    tap_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] c_lanes = LEN_W'(LANES);
  localparam logic [LEN_W-1:0] c_depth = LEN_W'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_rptr;
  logic [LEN_W-1:0]        r_ld_cnt;
  logic [ADDR_W-1:0]       r_wptr;
  logic                    r_err;
  logic [DATA_W-1:0]       r_mem [DEPTH];
  logic [DATA_W-1:0]       r_rd_data;
  logic [LANES*DATA_W-1:0] r_out_data;
  logic [LANES-1:0]        r_out_mask;

  logic [LEN_W-1:0]        w_remain;
  logic [LEN_W-1:0]        w_k;
  logic                    w_len_ok;
  logic                    w_in_fire;
  logic                    w_last_in;
  logic                    w_load_done;
  logic                    w_out_fire;
  logic [ADDR_W-1:0]       w_rd_addr;

  always_comb begin
    w_remain    = r_len - r_rptr;
    w_k         = (w_remain > c_lanes) ? c_lanes : w_remain;
    w_len_ok    = (len != '0) && (len <= c_depth);
    w_in_fire   = in_valid && (r_state == ST_FILL);
    w_last_in   = w_in_fire && (LEN_W'(r_wptr) == (r_len - LEN_W'(1)));
    w_load_done = (r_state == ST_LOAD) && (r_ld_cnt == w_k);
    w_out_fire  = (r_state == ST_PRESENT) && out_ready;
    w_rd_addr   = r_rptr[ADDR_W-1:0] + r_ld_cnt[ADDR_W-1:0];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE:    if (start && w_len_ok) w_next = ST_FILL;
      ST_FILL: begin
        in_ready = 1'b1;
        if (w_last_in) w_next = ST_LOAD;
      end
      ST_LOAD:    if (w_load_done) w_next = ST_PRESENT;
      ST_PRESENT: begin
        out_valid = 1'b1;
        if (w_out_fire) w_next = ((r_rptr + w_k) < r_len) ? ST_LOAD : ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default:    w_next = ST_IDLE;
    endcase
    if (abort) w_next = ST_IDLE;
  end

  // LOAD cycle n issues read n and captures the byte read in cycle n-1.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_len      <= '0;
      r_rptr     <= '0;
      r_ld_cnt   <= '0;
      r_wptr     <= '0;
      r_err      <= 1'b0;
      r_out_data <= '0;
      r_out_mask <= '0;
    end else begin
      if ((r_state == ST_IDLE) && start && !abort) begin
        if (w_len_ok) begin
          r_len  <= len;
          r_wptr <= '0;
          r_rptr <= '0;
          r_err  <= 1'b0;
        end else begin
          r_err  <= 1'b1;
        end
      end
      if (w_in_fire) r_wptr <= r_wptr + ADDR_W'(1);
      if (r_state == ST_LOAD) begin
        r_ld_cnt <= w_load_done ? '0 : r_ld_cnt + LEN_W'(1);
        if (r_ld_cnt == '0) begin
          r_out_data <= '0;
          r_out_mask <= '0;
        end else begin
          for (int i = 0; i < LANES; i++) begin
            if (r_ld_cnt == LEN_W'(i + 1)) begin
              r_out_data[i*DATA_W +: DATA_W] <= r_rd_data;
              r_out_mask[i]                  <= 1'b1;
            end
          end
        end
      end else begin
        r_ld_cnt <= '0;
      end
      if (w_out_fire) r_rptr <= r_rptr + w_k;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_in_fire) r_mem[r_wptr] <= in_data;
    r_rd_data <= r_mem[w_rd_addr];
  end

  assign out_data  = r_out_data;
  assign out_mask  = r_out_mask;
  assign err       = r_err;
  assign tap_valid = tap_en & in_valid & in_ready;
  assign tap_data  = tap_valid ? in_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_steer_frame_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_steer_frame_engine
// Purpose  : Directed plus randomised self-checking bench for steer_frame_engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_steer_frame_engine;

  localparam int DATA_W = 8;
  localparam int LANES  = 8;
  localparam int DEPTH  = 64;
  localparam int LEN_W  = 7;

  logic                    CLK = 1'b0;
  logic                    RESET;
  logic                    start;
  logic [LEN_W-1:0]        len;
  logic                    abort;
  logic                    tap_en;
  logic [DATA_W-1:0]       in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] out_data;
  logic [LANES-1:0]        out_mask;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       tap_data;
  logic                    tap_valid;
  logic                    busy;
  logic                    done;
  logic                    err;

  int errors = 0;
  int checks = 0;
  logic [7:0] bytes_q [DEPTH];

  steer_frame_engine #(
    .DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH), .LEN_W(LEN_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .len(len), .abort(abort),
    .tap_en(tap_en), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_mask(out_mask), .out_valid(out_valid),
    .out_ready(out_ready), .tap_data(tap_data), .tap_valid(tap_valid),
    .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference frame f of an L-byte transfer: lane j carries byte 8f+j when it exists.
  function automatic logic [63:0] exp_data(input int L, input int f);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < LANES; j++)
      if (f*LANES + j < L) r[j*8 +: 8] = bytes_q[f*LANES + j];
    return r;
  endfunction

  function automatic logic [63:0] exp_mask(input int L, input int f);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < LANES; j++)
      if (f*LANES + j < L) r[j] = 1'b1;
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},  in_ready,  1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"},  out_data,  64'h0);
    chk({tag, "_out_mask"},  out_mask,  8'h0);
    chk({tag, "_done"},      done,      1'b0);
    chk({tag, "_err"},       err,       1'b0);
    chk({tag, "_busy"},      busy,      1'b0);
    chk({tag, "_tap_valid"}, tap_valid, 1'b0);
    chk({tag, "_tap_data"},  tap_data,  8'h0);
  endtask

  task automatic start_xfer(input int L);
    start = 1'b1;
    len   = LEN_W'(L);
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_in_ready", in_ready, 1'b1);
    chk("start_err_clear", err, 1'b0);
  endtask

  task automatic fill(input int n, input bit gaps, input bit fixed);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          tick();
          chk("fill_gap_ready", in_ready, 1'b1);
        end
      end
      b          = fixed ? 8'(i) : 8'($urandom);
      bytes_q[i] = b;
      in_data    = b;
      in_valid   = 1'b1;
      tap_en     = 1'($urandom_range(0, 1));
      #1;
      chk("tap_valid", tap_valid, tap_en);
      chk("tap_data", tap_data, tap_en ? b : 8'h0);
      tick();
    end
    in_valid = 1'b0;
    tap_en   = 1'b0;
  endtask

  // Expects k+1 LOAD cycles with out_valid low, then the frame presented.
  task automatic wait_present(input int L, input int f);
    int k;
    k = (L - f*LANES > LANES) ? LANES : L - f*LANES;
    for (int n = 0; n <= k; n++) begin
      chk("load_valid_low", out_valid, 1'b0);
      tick();
    end
    chk("present_valid", out_valid, 1'b1);
    chk("present_data", out_data, exp_data(L, f));
    chk("present_mask", out_mask, exp_mask(L, f));
  endtask

  task automatic drain(input int L, input int bp);
    int nf;
    nf = (L + LANES - 1) / LANES;
    for (int f = 0; f < nf; f++) begin
      wait_present(L, f);
      if (f == 0 && bp > 0) begin
        out_ready = 1'b0;
        repeat (bp) begin
          tick();
          chk("bp_valid", out_valid, 1'b1);
          chk("bp_data_stable", out_data, exp_data(L, f));
          chk("bp_mask_stable", out_mask, exp_mask(L, f));
        end
      end
      out_ready = 1'b1;
      tick();
    end
    chk("done_pulse", done, 1'b1);
    chk("done_busy", busy, 1'b1);
    chk("done_valid_low", out_valid, 1'b0);
    tick();
    chk("after_done", done, 1'b0);
    chk("after_busy", busy, 1'b0);
    chk("after_in_ready", in_ready, 1'b0);
  endtask

  task automatic xfer(input int L, input bit gaps, input bit fixed, input int bp);
    start_xfer(L);
    fill(L, gaps, fixed);
    drain(L, bp);
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; len = '0; abort = 1'b0; tap_en = 1'b0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    chk_all_zero("reset");
    RESET = 1'b0;
    tap_en = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    #1;
    chk("idle_tap_valid", tap_valid, 1'b0);
    chk("idle_tap_data", tap_data, 8'h0);
    tap_en = 1'b0; in_valid = 1'b0;
    tick();

    // full frames, short last frame, backpressure with input gaps
    xfer(16, 1'b0, 1'b1, 0);
    xfer(11, 1'b0, 1'b1, 0);
    xfer(16, 1'b1, 1'b0, 5);

    // illegal lengths
    start = 1'b1; len = '0;
    tick();
    start = 1'b0;
    chk("len0_err", err, 1'b1);
    chk("len0_busy", busy, 1'b0);
    start = 1'b1; len = LEN_W'(DEPTH + 1);
    tick();
    start = 1'b0;
    chk("lenbig_err", err, 1'b1);
    chk("lenbig_busy", busy, 1'b0);
    tick();
    chk("err_sticky", err, 1'b1);
    xfer(4, 1'b0, 1'b0, 0);

    // abort after 3 of 8 bytes
    start_xfer(8);
    fill(3, 1'b0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_in_ready", in_ready, 1'b0);
    chk("abort_done", done, 1'b0);
    tick();
    chk("abort_no_done", done, 1'b0);

    // abort coinciding with start wins
    start = 1'b1; len = LEN_W'(8); abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", busy, 1'b0);
    chk("abort_start_in_ready", in_ready, 1'b0);

    // boundary and random lengths with random gaps and backpressure
    xfer(1, 1'b1, 1'b0, 0);
    xfer(DEPTH, 1'b1, 1'b0, 2);
    xfer(LANES, 1'b0, 1'b0, 1);
    repeat (4) xfer(int'($urandom_range(1, DEPTH)), 1'b1, 1'b0, int'($urandom_range(0, 3)));

    // reset asserted while a frame is presented
    start_xfer(8);
    fill(8, 1'b0, 1'b0);
    wait_present(8, 0);
    out_ready = 1'b0;
    tick();
    chk("pre_reset_valid", out_valid, 1'b1);
    RESET = 1'b1;
    #1;
    chk_all_zero("async_reset");
    tick();
    RESET = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("post_reset_busy", busy, 1'b0);
    xfer(9, 1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
